// File: rtl/ram_dp_pipe.sv
// Simple-dual-port RAM with byte-enable writes, RD_LATENCY-deep read pipeline,
// selectable read-during-write policy and out-of-range flagging.
module ram_dp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int RW_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  w_in, r_in;
  logic                  wr_acc, rd_acc;
  logic                  oob_hit;
  logic [IW-1:0]         widx, ridx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] stage0;

  logic [RD_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0] pd [RD_LATENCY];

  assign w_in    = ({1'b0, waddr} < DEPTH_W);
  assign r_in    = ({1'b0, raddr} < DEPTH_W);
  assign widx    = waddr[IW-1:0];
  assign ridx    = raddr[IW-1:0];
  assign wr_acc  = cs && wen && w_in;
  assign rd_acc  = cs && ren;
  assign oob_hit = cs && ((wen && !w_in) || (ren && !r_in));

  // Write-first merges the incoming lanes over the stored word on a same-address hit.
  always_comb begin
    rd_word = mem[ridx];
    if (RW_MODE == 1 && wr_acc && waddr == raddr) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    stage0 = r_in ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Each stage's data only moves with a valid token, so the last stage holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv  <= '0;
      err <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) pd[0] <= stage0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
      err <= oob_hit;
    end
  end

  assign rvalid = pv[RD_LATENCY-1];
  assign rdata  = pd[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Directed bench: three RAM configurations share one stimulus stream and are
// checked at their own read latencies.
module tb_ram_dp_pipe;

  logic        clk = 1'b0;
  logic        rst, cs, wen, ren;
  logic [7:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;

  logic [31:0] rdata1, rdata2, rdata3;
  logic        rvalid1, rvalid2, rvalid3;
  logic        err1, err2, err3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // u1: L=1 read-first DEPTH=200; u2: L=2 write-first full depth; u3: L=3 write-first DEPTH=200
  ram_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .RD_LATENCY(1), .RW_MODE(0)) u1 (
    .clk(clk), .rst(rst), .cs(cs), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .err(err1));
  ram_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .RD_LATENCY(2), .RW_MODE(1)) u2 (
    .clk(clk), .rst(rst), .cs(cs), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .err(err2));
  ram_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .RD_LATENCY(3), .RW_MODE(1)) u3 (
    .clk(clk), .rst(rst), .cs(cs), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rdata3), .rvalid(rvalid3), .err(err3));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wen = 1'b1; waddr = a; wdata = d; wbe = be; ren = 1'b0;
    tick();
    wen = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] e);
    ren = 1'b1; raddr = a; wen = 1'b0;
    tick();
    ren = 1'b0;
    chk({tag, "_v1"}, rvalid1, 1); chk({tag, "_d1"}, rdata1, e);
    tick();
    chk({tag, "_v2"}, rvalid2, 1); chk({tag, "_d2"}, rdata2, e);
    tick();
    chk({tag, "_v3"}, rvalid3, 1); chk({tag, "_d3"}, rdata3, e);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; wen = 1'b0; ren = 1'b1;
    waddr = '0; raddr = 8'h10; wdata = '0; wbe = '0;

    // Reset held with a pending read: outputs stay clear
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_v1", rvalid1, 0); chk("rst_v2", rvalid2, 0); chk("rst_v3", rvalid3, 0);
      chk("rst_d1", rdata1, 0);  chk("rst_d3", rdata3, 0);
      chk("rst_e1", err1, 0);    chk("rst_e3", err3, 0);
    end

    // First read at the first edge with rst low, latency per instance
    rst = 1'b0;
    tick();
    ren = 1'b0;
    chk("first_v1", rvalid1, 1); chk("first_v2_early", rvalid2, 0); chk("first_e1", err1, 0);
    tick();
    chk("first_v1_done", rvalid1, 0); chk("first_v2", rvalid2, 1); chk("first_v3_early", rvalid3, 0);
    tick();
    chk("first_v2_done", rvalid2, 0); chk("first_v3", rvalid3, 1);
    tick();
    chk("first_v3_done", rvalid3, 0);

    // Byte enables
    wr(8'h10, 32'hAABBCCDD, 4'hF);
    wr(8'h10, 32'h11223344, 4'b0101);
    read_check("be", 8'h10, 32'hAA22CC44);

    // cs low ignores a write
    cs = 1'b0;
    wr(8'h10, 32'h0, 4'hF);
    cs = 1'b1;
    read_check("cs_low", 8'h10, 32'hAA22CC44);

    // Throughput: fill 0..7, then back-to-back reads
    for (int a = 0; a < 8; a++) wr(8'(a), 32'(a) * 32'h01010101, 4'hF);
    for (int t = 0; t < 12; t++) begin
      ren = (t < 8); raddr = 8'(t);
      tick();
      chk("tp_v1", rvalid1, (t < 8) ? 1 : 0);
      if (t < 8) chk("tp_d1", rdata1, 32'(t) * 32'h01010101);
      chk("tp_v3", rvalid3, (t >= 2 && t < 10) ? 1 : 0);
      if (t >= 2 && t < 10) chk("tp_d3", rdata3, 32'(t - 2) * 32'h01010101);
    end
    ren = 1'b0;
    tick();

    // Collision on addr 5
    wr(8'h05, 32'h0, 4'hF);
    wen = 1'b1; waddr = 8'h05; wdata = 32'hFFFF0000; wbe = 4'b1100;
    ren = 1'b1; raddr = 8'h05;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("col_rf_d1", rdata1, 32'h00000000);
    tick();
    chk("col_wf_d2", rdata2, 32'hFFFF0000);
    tick();
    chk("col_wf_d3", rdata3, 32'hFFFF0000);
    read_check("col_after", 8'h05, 32'hFFFF0000);

    // Out of range on DEPTH=200 instances (in range on u2)
    wr(8'd50, 32'h0BADBEEF, 4'hF);
    wen = 1'b1; waddr = 8'd250; wdata = 32'h12345678; wbe = 4'hF;
    ren = 1'b1; raddr = 8'd250;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("oob_e1", err1, 1); chk("oob_e3", err3, 1); chk("oob_e2", err2, 0);
    chk("oob_v1", rvalid1, 1); chk("oob_d1", rdata1, 0);
    tick();
    chk("oob_e1_pulse", err1, 0); chk("oob_e3_pulse", err3, 0);
    chk("oob_v2", rvalid2, 1); chk("oob_d2", rdata2, 32'h12345678);
    tick();
    chk("oob_v3", rvalid3, 1); chk("oob_d3", rdata3, 0);
    read_check("oob_alias", 8'd50, 32'h0BADBEEF);

    // Reset mid-flight; the write during reset must be dropped
    ren = 1'b1; raddr = 8'h01;
    tick();
    rst = 1'b1; raddr = 8'h02; wen = 1'b1; waddr = 8'h07; wdata = 32'hDEADDEAD; wbe = 4'hF;
    tick();
    rst = 1'b0; ren = 1'b0; wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_v2", rvalid2, 0); chk("mid_d2", rdata2, 0);
      chk("mid_v3", rvalid3, 0); chk("mid_d3", rdata3, 0);
      tick();
    end
    read_check("rst_wr", 8'h07, 32'h07070707);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_dp_pipe.md
# ram_dp_pipe

Parametrised simple-dual-port RAM: one write port and one independent read port, both gated by a common chip select. It generalises the team's single-width RAM with byte-enable writes, a configurable read pipeline (1–3 cycles) with a read-valid strobe, selectable read-during-write behaviour and out-of-range address flagging. It sits behind the same driver/monitor clocking scheme as the existing RAM bench and is the memory primitive for the next-generation datapath buffers.

## Interface
- DATA_WIDTH, 32, data word width; must be a multiple of 8
- ADDR_WIDTH, 8, address width for both ports
- DEPTH, 2**ADDR_WIDTH, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
- RD_LATENCY, 1, read latency in cycles; legal values 1, 2, 3
- RW_MODE, 0, same-address collision policy: 0 = read-first (old data), 1 = write-first (new data)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cs  in  1  chip select; when low, neither port performs an access
- wen  in  1  write enable
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- wbe  in  DATA_WIDTH/8  write byte enables; bit i controls wdata[8i+7:8i]
- ren  in  1  read enable
- raddr  in  ADDR_WIDTH  read address
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata is valid this cycle
- err  out  1  one-cycle pulse: an access hit an out-of-range address

## Operation
- Write: cs && wen sampled high at an edge, and waddr < DEPTH. Byte lanes with wbe[i]=1 are updated and the other lanes keep their contents. wbe = 0 is a legal no-op write.
- Read: cs && ren sampled high at an edge. The request enters a RD_LATENCY-deep pipeline of {valid, data}. The array read happens in stage 0, and the remaining stages are plain registers.
- Collision: a read and a write to the same in-range address in the same cycle.
  - RW_MODE=0: the read returns the contents from before the write.
  - RW_MODE=1: the read returns the merged word, with new bytes on enabled lanes and old bytes on the others.
- Out of range: waddr >= DEPTH or raddr >= DEPTH on an access. The write is dropped. The read still produces rvalid with rdata = 0. err pulses once for that edge, covering either or both ports. Out-of-range addresses can only occur when DEPTH < 2**ADDR_WIDTH.
- cs low: wen, ren, addresses and data are ignored. The pipeline keeps advancing, so in-flight reads still complete.
- Back-to-back reads are allowed every cycle, giving full throughput with no stalls. There is no backpressure.
- rdata holds its last valid value while rvalid = 0.
- Memory contents are not initialised by reset. They are undefined until written.

## Timing
- Reset: while rst is sampled high, all requests are ignored. After that edge, rvalid = 0, rdata = 0, err = 0, and all pipeline valid bits are 0.
- Reset mid-operation: in-flight reads are discarded and produce no rvalid afterwards.
  - A write presented in the same cycle as rst is not performed.
- First access: the first accepted access is at the first edge with rst low.
- Read latency: a read sampled at edge k drives rvalid = 1 and rdata in the cycle after edge k+RD_LATENCY-1.
  - A clocking-block monitor sees the result at edge k+RD_LATENCY.
  - Example: RD_LATENCY=1 means a request at edge k is visible at edge k+1.
- Write visibility: a write at edge k is visible to a read sampled at edge k+1, in both modes.
  - In RW_MODE=1 it is also visible to a read sampled at edge k itself.
- err timing: err is registered and asserted in the cycle after the offending edge. It has the same timing as rvalid when RD_LATENCY=1 and is independent of RD_LATENCY otherwise.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert rst for 3 cycles with cs=1, ren=1 -> rvalid=0, rdata=0, err=0 throughout and one cycle after release. A read issued at the first edge with rst low returns rvalid 1 cycle later (RD_LATENCY=1).
- Byte enables: write 0xAABBCCDD to addr 0x10 with wbe=4'hF, then 0x11223344 with wbe=4'b0101, then read 0x10 -> rdata = 0xAA22CC44.
- Latency/throughput (RD_LATENCY=3): fill addrs 0..7 with value = addr*0x01010101, then issue reads 0..7 on consecutive cycles -> 8 consecutive rvalid cycles starting 3 edges after the first request, data in order.
- Collision: preload addr 5 with 0x0; in one cycle write 0xFFFF0000 (wbe=4'b1100) to addr 5 and read addr 5 -> RW_MODE=0 returns 0x00000000, RW_MODE=1 returns 0xFFFF0000. A following read returns 0xFFFF0000 in both modes.
- Out of range (ADDR_WIDTH=8, DEPTH=200): write 0x12345678 to addr 250 and read addr 250 -> err pulses exactly 1 cycle, rvalid=1 with rdata=0. A read of addr 250-200=50 does not return 0x12345678.
- Reset mid-flight (RD_LATENCY=2): issue reads at edges k and k+1, assert rst at edge k+1 -> no rvalid ever appears for either request, and rdata=0.
